// File: rtl/elevator_pkg.sv
// Shared elevator definitions: floor geometry, loader state encoding and a
// small helper that maps an unset start floor onto the ground floor.
package elevator_pkg;
  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W    = 3;
  localparam int PASS_W     = 6;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [FLOOR_W-1:0] norm_floor(input logic [FLOOR_W-1:0] f);
    return (f == 3'd0) ? 3'd1 : f;
  endfunction
endpackage

// File: rtl/floor_slot.sv
// One floor's two-passenger request register; slot_a fills first, then slot_b.
module floor_slot
  import elevator_pkg::*;
(
  input  logic               clock,
  input  logic               reset_start,
  input  logic               clr,
  input  logic               we,
  input  logic [FLOOR_W-1:0] dst,
  output logic [PASS_W-1:0]  word,
  output logic               full
);
  logic [FLOOR_W-1:0] slot_a_r;
  logic [FLOOR_W-1:0] slot_b_r;

  // Slot storage: reset/clear empties both, a write lands in the first free slot.
  always_ff @(posedge clock) begin
    if (!reset_start) begin
      slot_a_r <= 3'd0;
      slot_b_r <= 3'd0;
    end else if (clr) begin
      slot_a_r <= 3'd0;
      slot_b_r <= 3'd0;
    end else if (we) begin
      if (slot_a_r == 3'd0) begin
        slot_a_r <= dst;
      end else if (slot_b_r == 3'd0) begin
        slot_b_r <= dst;
      end else begin
        slot_a_r <= slot_a_r;
      end
    end else begin
      slot_a_r <= slot_a_r;
    end
  end

  assign word = {slot_b_r, slot_a_r};
  assign full = (slot_a_r != 3'd0) && (slot_b_r != 3'd0);
endmodule

// File: rtl/passenger_loader.sv
// Collects passenger requests into per-floor slot words, then starts the
// elevator core and times the run until the building empties or times out.
module passenger_loader
  import elevator_pkg::*;
#(
  parameter int unsigned MAX_CYCLES = 200
) (
  input  logic               clock,
  input  logic               reset_start,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [FLOOR_W-1:0] req_src,
  input  logic [FLOOR_W-1:0] req_dst,
  input  logic               commit,
  input  logic               clear,
  input  logic [FLOOR_W-1:0] init_1,
  input  logic [FLOOR_W-1:0] init_2,
  input  logic [PASS_W-1:0]  remaining_1,
  input  logic [PASS_W-1:0]  remaining_2,
  input  logic [PASS_W-1:0]  remaining_3,
  input  logic [PASS_W-1:0]  remaining_4,
  input  logic [PASS_W-1:0]  remaining_5,
  input  logic [PASS_W-1:0]  remaining_6,
  input  logic [PASS_W-1:0]  remaining_7,
  input  logic [PASS_W-1:0]  boarding_1,
  input  logic [PASS_W-1:0]  boarding_2,
  output logic [PASS_W-1:0]  passenger_1,
  output logic [PASS_W-1:0]  passenger_2,
  output logic [PASS_W-1:0]  passenger_3,
  output logic [PASS_W-1:0]  passenger_4,
  output logic [PASS_W-1:0]  passenger_5,
  output logic [PASS_W-1:0]  passenger_6,
  output logic [PASS_W-1:0]  passenger_7,
  output logic [FLOOR_W-1:0] init_elevator_1,
  output logic [FLOOR_W-1:0] init_elevator_2,
  output logic               core_start,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic               req_err,
  output logic [7:0]         trip_cycles
);
  state_t             state_r, next_state_s;
  logic               ready_r, busy_r, done_r, core_start_r, timeout_r, req_err_r;
  logic [7:0]         trip_r, trip_inc_s;
  logic [FLOOR_W-1:0] init1_r, init2_r;
  logic               hs_s, bad_s, we_s, clr_slots_s, all_zero_s, timeout_hit_s;
  logic [NUM_FLOORS:0] full_s;
  logic [PASS_W-1:0]  word_s [1:NUM_FLOORS];

  assign hs_s        = req_valid && ready_r;
  assign bad_s       = (req_src == 3'd0) || (req_dst == 3'd0) || (req_src == req_dst) || full_s[req_src];
  assign we_s        = hs_s && !bad_s;
  assign clr_slots_s = (state_r == S_DONE) && clear;
  assign all_zero_s  = ~|{remaining_1, remaining_2, remaining_3, remaining_4, remaining_5,
                          remaining_6, remaining_7, boarding_1, boarding_2};
  assign trip_inc_s    = (trip_r == 8'd255) ? 8'd255 : trip_r + 8'd1;
  assign timeout_hit_s = ({24'd0, trip_inc_s} >= MAX_CYCLES);
  assign full_s[0]     = 1'b0;

  for (genvar g = 1; g <= NUM_FLOORS; g++) begin : g_floor
    floor_slot u_slot (
      .clock      (clock),
      .reset_start(reset_start),
      .clr        (clr_slots_s),
      .we         (we_s && (req_src == FLOOR_W'(g))),
      .dst        (req_dst),
      .word       (word_s[g]),
      .full       (full_s[g])
    );
  end

  // Next-state decode for the load/start/run/done sequence.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:  if (hs_s) next_state_s = S_LOAD; else next_state_s = S_IDLE;
      S_LOAD:  if (commit) next_state_s = S_START; else next_state_s = S_LOAD;
      S_START: next_state_s = S_RUN;
      S_RUN:   if (all_zero_s || timeout_hit_s) next_state_s = S_DONE; else next_state_s = S_RUN;
      S_DONE:  if (clear) next_state_s = S_IDLE; else next_state_s = S_DONE;
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register plus status outputs registered against the next state.
  always_ff @(posedge clock) begin
    if (!reset_start) begin
      state_r      <= S_IDLE;
      ready_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      core_start_r <= 1'b0;
      timeout_r    <= 1'b0;
      req_err_r    <= 1'b0;
      trip_r       <= 8'd0;
      init1_r      <= 3'd1;
      init2_r      <= 3'd1;
    end else begin
      state_r      <= next_state_s;
      ready_r      <= (next_state_s == S_IDLE) || (next_state_s == S_LOAD);
      busy_r       <= (next_state_s != S_IDLE);
      done_r       <= (next_state_s == S_DONE);
      core_start_r <= (next_state_s == S_START);
      if (hs_s && bad_s) begin
        req_err_r <= 1'b1;
      end else if (clr_slots_s) begin
        req_err_r <= 1'b0;
      end
      if ((state_r == S_LOAD) && commit) begin
        init1_r <= norm_floor(init_1);
        init2_r <= norm_floor(init_2);
      end
      // Completion wins over timeout, so timeout only flags a run that is still occupied.
      case (state_r)
        S_START: begin
          trip_r    <= 8'd0;
          timeout_r <= 1'b0;
        end
        S_RUN: begin
          trip_r    <= trip_inc_s;
          timeout_r <= !all_zero_s && timeout_hit_s;
        end
        default: begin
          trip_r    <= trip_r;
          timeout_r <= timeout_r;
        end
      endcase
    end
  end

  assign req_ready       = ready_r;
  assign busy            = busy_r;
  assign done            = done_r;
  assign core_start      = core_start_r;
  assign timeout         = timeout_r;
  assign req_err         = req_err_r;
  assign trip_cycles     = trip_r;
  assign init_elevator_1 = init1_r;
  assign init_elevator_2 = init2_r;
  assign passenger_1     = word_s[1];
  assign passenger_2     = word_s[2];
  assign passenger_3     = word_s[3];
  assign passenger_4     = word_s[4];
  assign passenger_5     = word_s[5];
  assign passenger_6     = word_s[6];
  assign passenger_7     = word_s[7];
endmodule

// File: doc/passenger_loader.md
PASSENGER_LOADER -- requirements
Module: passenger_loader

Interface
REQ-001 Parameter: MAX_CYCLES, default 200; run timeout in clock cycles, legal 1..255.
REQ-002 Ports, one per line: name  direction  width  meaning.
- clock  in  1  single clock; all state changes on its rising edge.
- reset_start  in  1  synchronous, active-low reset.
- req_valid  in  1  a passenger request is offered.
- req_ready  out  1  loader accepts the request this cycle.
- req_src  in  3  origin floor, 1..7.
- req_dst  in  3  destination floor, 1..7.
- commit  in  1  loading finished; start the run.
- clear  in  1  leave DONE.
- init_1, init_2  in  3 each  requested start floors of elevators 1 and 2.
- remaining_1..7  in  6 each  floor occupancy fed back from the elevator core.
- boarding_1, boarding_2  in  6 each  car occupancy fed back from the elevator core.
- passenger_1..7  out  6 each  floor request words for the core.
- init_elevator_1, init_elevator_2  out  3 each  latched start floors.
- core_start  out  1  one-cycle start pulse to the core.
- busy  out  1  state is not IDLE.
- done  out  1  run finished, held until clear.
- timeout  out  1  run ended by MAX_CYCLES, valid while done.
- req_err  out  1  sticky flag: a request was rejected.
- trip_cycles  out  8  RUN length in cycles, saturating at 255.

Function
REQ-003 Floor word encoding: passenger_N = {slot_b[2:0], slot_a[2:0]}; each slot holds a destination floor; 0 means empty; two passengers per floor maximum.
REQ-004 States: IDLE, LOAD, START, RUN, DONE.
REQ-005 req_ready shall be 1 in IDLE and LOAD, 0 otherwise; a handshake completes when req_valid=1 and req_ready=1.
REQ-006 The first handshake in IDLE shall move the state to LOAD.
REQ-007 An accepted request shall write req_dst into slot_a of floor req_src if slot_a is empty, otherwise into slot_b.
REQ-008 A request shall be dropped and req_err set when src=0, dst=0, src=dst, or both slots are full; the handshake still completes.
REQ-009 In LOAD, commit=1 shall latch init_1 and init_2 into init_elevator_1 and init_elevator_2 and move to START; an init value of 0 shall be latched as 1.
REQ-010 commit in the same cycle as a handshake shall include that request before the state moves on.
REQ-011 commit in IDLE shall be ignored.
REQ-012 START shall last one cycle with core_start=1, then move to RUN with trip_cycles cleared.
REQ-013 RUN shall increment trip_cycles every cycle, saturating at 255.
REQ-014 RUN shall exit to DONE in the first cycle in which all remaining_* and boarding_* are zero (timeout=0), or when trip_cycles reaches MAX_CYCLES (timeout=1); completion has priority if both occur in the same cycle.
REQ-015 DONE shall hold done=1 and freeze trip_cycles and timeout.
REQ-016 clear=1 in DONE shall move to IDLE and zero all floor slots and req_err; clear in any other state shall be ignored.
REQ-017 passenger_1..7 shall be stable from START through DONE.

Reset
REQ-018 While reset_start=0 at a clock edge, the block shall go to IDLE and every output shall be 0 (init_elevator_1 and init_elevator_2 = 1), from any state, including mid-RUN.
REQ-019 Reset shall take priority over every other input.

Structure
REQ-020 Shared package elevator_pkg shall hold NUM_FLOORS=7, FLOOR_W=3, PASS_W=6 and the state enumeration.
REQ-021 Sub-module floor_slot shall implement one two-slot floor register with write-enable, clear and full outputs, instantiated 7 times.

Verification
REQ-022 Reset, then requests (2->5),(2->6),(2->7) and commit: passenger_2=6'b110_101, req_err=1, core_start pulses once.
REQ-023 Request (3->3) then (0->4): both dropped, req_err=1, all passenger_* stay 0.
REQ-024 Commit with init_1=0, init_2=4: init_elevator_1=1, init_elevator_2=4.
REQ-025 RUN with feedback zeroed 10 cycles after core_start: done=1, timeout=0, trip_cycles=10.
REQ-026 MAX_CYCLES=20 with feedback never zero: done=1, timeout=1, trip_cycles=20.
REQ-027 reset_start=0 mid-RUN: next cycle busy=0, all passenger_*=0; clear then restores IDLE after DONE.
